// File: rtl/gpio_responder_if.sv
// CPU data-bus port of the GPIO block: address/store strobe in, read data and window hit out.
interface gpio_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        sel;

    modport master (output addr, wdata, we, input  rdata, sel);
    modport slave  (input  addr, wdata, we, output rdata, sel);
endinterface

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO: OUT/DIR/IEN/STAT/POL registers, 2-flop input sync,
// edge detect into sticky STAT and a level irq.
module gpio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    gpio_responder_if.slave  bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    typedef enum logic [2:0] {
        R_OUT = 3'd0, R_DIR = 3'd1, R_IN  = 3'd2, R_SET = 3'd3,
        R_CLR = 3'd4, R_IEN = 3'd5, R_STAT = 3'd6, R_POL = 3'd7
    } reg_off_e;

    logic [WIDTH-1:0] out_r, dir_r, ien_r, stat_r, pol_r;
    logic [WIDTH-1:0] s1, s2, p;
    logic [WIDTH-1:0] wd, ev, w1c;
    logic [1:0]       arm;
    logic             armed, wr;
    reg_off_e         off;
    logic [31:0]      rd;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.addr[1:0];

    assign bus.sel = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off     = reg_off_e'(bus.addr[4:2]);
    assign wr      = bus.we & bus.sel;
    assign wd      = bus.wdata[WIDTH-1:0];
    assign armed   = (arm == 2'd3);

    // Edges are ignored until the sync chain has filled with real pin values.
    assign ev  = armed ? ((pol_r & p & ~s2) | (~pol_r & s2 & ~p)) : '0;
    assign w1c = (wr && off == R_STAT) ? wd : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_r  <= '0;
            dir_r  <= '0;
            ien_r  <= '0;
            stat_r <= '0;
            pol_r  <= '0;
            s1     <= '0;
            s2     <= '0;
            p      <= '0;
            arm    <= 2'd0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            p  <= s2;
            if (!armed) arm <= arm + 2'd1;
            // New events win over a same-cycle write-one-to-clear.
            stat_r <= (stat_r & ~w1c) | ev;
            if (wr) begin
                case (off)
                    R_OUT:   out_r <= wd;
                    R_DIR:   dir_r <= wd;
                    R_SET:   out_r <= out_r | wd;
                    R_CLR:   out_r <= out_r & ~wd;
                    R_IEN:   ien_r <= wd;
                    R_POL:   pol_r <= wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        case (off)
            R_OUT:   rd[WIDTH-1:0] = out_r;
            R_DIR:   rd[WIDTH-1:0] = dir_r;
            R_IN:    rd[WIDTH-1:0] = s2;
            R_IEN:   rd[WIDTH-1:0] = ien_r;
            R_STAT:  rd[WIDTH-1:0] = stat_r;
            R_POL:   rd[WIDTH-1:0] = pol_r;
            default: rd = '0;
        endcase
    end

    assign bus.rdata = bus.sel ? rd : 32'h0;
    assign gpio_out  = out_r;
    assign gpio_oe   = dir_r;
    assign irq       = |(stat_r & ien_r);
endmodule
